// File: rtl/r3_mul_serial_p_if.sv
// r3_mul_serial_p_if: operand write port, result read port and status
// for the serial Z3 polynomial multiplier.
interface r3_mul_serial_p_if #(
    parameter int W  = 64,
    parameter int AW = 5
) ();
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_din;
    logic          start;
    logic [1:0]    mode;
    logic          acc_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_dout;
    logic          busy;
    logic          valid;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_addr,
        output wr_din,
        output start,
        output mode,
        output acc_en,
        output rd_addr,
        input  rd_dout,
        input  busy,
        input  valid
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_addr,
        input  wr_din,
        input  start,
        input  mode,
        input  acc_en,
        input  rd_addr,
        output rd_dout,
        output busy,
        output valid
    );
endinterface

// File: rtl/r3_mul_serial_p.sv
// r3_mul_serial_p: Horner-style serial multiplier over Z3 with optional
// accumulate, h = f*g (or h += f*g) mod x^P-x-1, x^P-1 or x^P+1.
module r3_mul_serial_p #(
    parameter int P  = 761,
    parameter int W  = 64,
    parameter int AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    r3_mul_serial_p_if.slave bus
);
    localparam int NW  = (2 * P + W - 1) / W;
    localparam int CPW = W / 2;
    localparam int CW  = $clog2(P);
    localparam int XW  = (NW > 1) ? $clog2(NW) : 1;

    typedef logic [P-1:0][1:0]  coef_t;
    typedef logic [NW-1:0][W-1:0] word_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [1:0] add3(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [1:0] neg3(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [1:0] mul3(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic [1:0] r;
        case (a)
            2'b01:   r = b;
            2'b10:   r = neg3(b);
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    mode_q;
    coef_t         f_q;
    coef_t         g_q;
    coef_t         h_q;
    coef_t         a_q;
    logic          busy_q;
    logic          valid_q;
    logic [W-1:0]  dout_q;

    coef_t         f_d;
    coef_t         g_d;
    coef_t         h_step;
    coef_t         wv;
    logic [P-1:0]  wm;
    word_t         h_words;
    logic [W-1:0]  rd_word;
    logic [CW-1:0] fidx;
    logic [1:0]    fb;
    logic [1:0]    t;
    logic [1:0]    s;
    logic          last;
    logic          idle;
    logic          wr_ok;
    logic          rd_ok;
    logic          we_f;
    logic          we_g;
    logic [XW-1:0] wi;
    logic [XW-1:0] ri;

    assign idle  = (state_q != S_RUN);
    assign last  = (cnt_q == CW'(P - 1));
    assign fidx  = CW'(P - 1) - cnt_q;
    assign wi    = bus.wr_addr[XW-1:0];
    assign ri    = bus.rd_addr[XW-1:0];
    assign wr_ok = ({1'b0, bus.wr_addr} < (AW + 1)'(NW));
    assign rd_ok = ({1'b0, bus.rd_addr} < (AW + 1)'(NW));
    assign we_f  = idle && !bus.start && bus.wr_en &&
                   wr_ok && !bus.wr_sel;
    assign we_g  = idle && !bus.start && bus.wr_en &&
                   wr_ok && bus.wr_sel;

    // Operand write: unpack one word, 11 codes become 0.
    always_comb begin
        wm = '0;
        wv = '0;
        for (int k = 0; k < P; k++) begin
            wm[k] = (int'(wi) == k / CPW);
            wv[k] = bus.wr_din[2 * (k % CPW) +: 2];
            if (wv[k] == 2'b11) wv[k] = 2'b00;
        end
    end

    always_comb begin
        f_d = f_q;
        g_d = g_q;
        for (int k = 0; k < P; k++) begin
            if (we_f && wm[k]) f_d[k] = wv[k];
            if (we_g && wm[k]) g_d[k] = wv[k];
        end
    end

    // One Horner step; the accumulate term is folded in on the last step
    // so the initial h is not scaled by x^P.
    always_comb begin
        t      = h_q[P-1];
        fb     = f_q[fidx];
        s      = 2'b00;
        h_step = '0;
        for (int j = 0; j < P; j++) begin
            s = h_q[(j + P - 1) % P];
            if (j == 0 && mode_q == 2'd2) s = neg3(s);
            if (j == 1 && (mode_q == 2'd0 || mode_q == 2'd3))
                s = add3(s, t);
            s = add3(s, mul3(fb, g_q[j]));
            if (last) s = add3(s, a_q[j]);
            h_step[j] = s;
        end
    end

    always_comb begin
        h_words = '0;
        for (int k = 0; k < P; k++)
            h_words[k / CPW][2 * (k % CPW) +: 2] = h_q[k];
        rd_word = rd_ok ? h_words[ri] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            a_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            busy_q  <= (state_q == S_RUN);
            valid_q <= (state_q == S_DONE);
            dout_q  <= rd_word;
            f_q     <= f_d;
            g_q     <= g_d;
            unique case (state_q)
                S_RUN: begin
                    h_q   <= h_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        mode_q  <= bus.mode;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        a_q     <= bus.acc_en ? h_q : '0;
                        h_q     <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.rd_dout = dout_q;
    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
endmodule

// File: tb/tb_r3_mul_serial_p.sv
// tb_r3_mul_serial_p: directed table for P=761/W=64 plus randomized
// trials for P=5/W=8 against a polynomial-arithmetic model.
module tb_r3_mul_serial_p;
    localparam int PB = 761;
    localparam int WB = 64;
    localparam int AB = 5;
    localparam int NB = 24;
    localparam int PS = 5;
    localparam int WS = 8;
    localparam int AS = 3;
    localparam logic [63:0] G760 = 64'h0001_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    r3_mul_serial_p_if #(.W(WB), .AW(AB)) bb ();
    r3_mul_serial_p_if #(.W(WS), .AW(AS)) sb ();

    r3_mul_serial_p #(.P(PB), .W(WB), .AW(AB)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bb)
    );
    r3_mul_serial_p #(.P(PS), .W(WS), .AW(AS)) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(sb)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] f0;
        logic [63:0] g0;
        logic [63:0] g23;
        logic [1:0]  mode;
        logic        acc;
        logic [63:0] exp0;
    } vec_t;
    vec_t tbl[9];

    int fm[PS];
    int gm[PS];
    int hm[PS];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // h = (acc ? h : 0) + f*g, reducing x^k for k >= P by the ring rule
    function automatic void model(input int m, input bit acc);
        int c[2*PS-1];
        int v;
        foreach (c[i]) c[i] = 0;
        for (int i = 0; i < PS; i++)
            for (int j = 0; j < PS; j++)
                c[i+j] += fm[i] * gm[j];
        for (int k = 2*PS-2; k >= PS; k--) begin
            v = c[k] % 3;
            if (m == 1) c[k-PS] += v;
            else if (m == 2) c[k-PS] += 2 * v;
            else begin
                c[k-PS] += v;
                c[k-PS+1] += v;
            end
        end
        for (int k = 0; k < PS; k++)
            hm[k] = ((acc ? hm[k] : 0) + c[k]) % 3;
    endfunction

    task automatic bwr(input logic sel, input int a, input logic [63:0] d);
        @(negedge clk);
        bb.wr_en = 1'b1;
        bb.wr_sel = sel;
        bb.wr_addr = AB'(a);
        bb.wr_din = d;
        @(posedge clk);
        #1 bb.wr_en = 1'b0;
    endtask

    task automatic bload(input logic [63:0] f0, input logic [63:0] g0,
                         input logic [63:0] g23);
        for (int a = 0; a < NB; a++) begin
            bwr(1'b0, a, (a == 0) ? f0 : 64'h0);
            bwr(1'b1, a, (a == 0) ? g0 : ((a == 23) ? g23 : 64'h0));
        end
    endtask

    task automatic bread(input int a, output logic [63:0] d);
        @(negedge clk);
        bb.rd_addr = AB'(a);
        @(posedge clk);
        #1 d = bb.rd_dout;
    endtask

    task automatic bwait(output int lat);
        lat = 0;
        while (lat < PB + 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bb.valid) break;
        end
    endtask

    task automatic brun(input logic [1:0] m, input logic acc,
                        output int lat, output logic b1, output logic v1);
        @(negedge clk);
        bb.start = 1'b1;
        bb.mode = m;
        bb.acc_en = acc;
        @(posedge clk);
        #1 bb.start = 1'b0;
        lat = 0;
        b1 = 1'b0;
        v1 = 1'b1;
        while (lat < PB + 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                b1 = bb.busy;
                v1 = bb.valid;
            end
            if (bb.valid) break;
        end
    endtask

    task automatic bcheck(input string nm, input logic [63:0] e0);
        logic [63:0] d;
        for (int a = 0; a < 32; a++) begin
            bread(a, d);
            chk(nm, d, (a == 0) ? e0 : 64'h0);
        end
    endtask

    task automatic swr(input logic sel, input int a, input logic [7:0] d);
        @(negedge clk);
        sb.wr_en = 1'b1;
        sb.wr_sel = sel;
        sb.wr_addr = AS'(a);
        sb.wr_din = d;
        @(posedge clk);
        #1 sb.wr_en = 1'b0;
    endtask

    task automatic sread(input int a, output logic [7:0] d);
        @(negedge clk);
        sb.rd_addr = AS'(a);
        @(posedge clk);
        #1 d = sb.rd_dout;
    endtask

    task automatic srun(input logic [1:0] m, input logic acc,
                        output int lat);
        @(negedge clk);
        sb.start = 1'b1;
        sb.mode = m;
        sb.acc_en = acc;
        @(posedge clk);
        #1 sb.start = 1'b0;
        lat = 0;
        while (lat < PS + 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (sb.valid) break;
        end
    endtask

    initial begin
        int lat;
        logic b1;
        logic v1;
        logic [7:0] d8;
        logic [1:0] fcd[PS];
        logic [1:0] gcd[PS];
        logic [1:0] m;
        logic acc;
        logic [7:0] e0;
        logic [7:0] e1;

        tbl[0] = '{64'h4, 64'h0, G760, 2'd0, 1'b1, 64'h5};
        tbl[1] = '{64'h4, 64'h0, G760, 2'd0, 1'b1, 64'hA};
        tbl[2] = '{64'h4, 64'h0, G760, 2'd0, 1'b0, 64'h5};
        tbl[3] = '{64'h4, 64'h0, G760, 2'd1, 1'b0, 64'h1};
        tbl[4] = '{64'h4, 64'h0, G760, 2'd2, 1'b0, 64'h2};
        tbl[5] = '{64'h4, 64'h0, G760, 2'd3, 1'b0, 64'h5};
        tbl[6] = '{64'h2, 64'h2, 64'h0, 2'd0, 1'b0, 64'h1};
        tbl[7] = '{64'h2, 64'h2, 64'h0, 2'd0, 1'b1, 64'h2};
        tbl[8] = '{64'h2, 64'h2, 64'h0, 2'd2, 1'b1, 64'h0};

        {bb.wr_en, bb.wr_sel, bb.start, bb.acc_en} = '0;
        bb.wr_addr = '0;
        bb.wr_din = '0;
        bb.mode = '0;
        bb.rd_addr = '0;
        {sb.wr_en, sb.wr_sel, sb.start, sb.acc_en} = '0;
        sb.wr_addr = '0;
        sb.wr_din = '0;
        sb.mode = '0;
        sb.rd_addr = '0;
        foreach (hm[k]) hm[k] = 0;

        rst = 1'b0;
        #3;
        chk("rst_busy", 64'(bb.busy), 64'h0);
        chk("rst_valid", 64'(bb.valid), 64'h0);
        chk("rst_dout", bb.rd_dout, 64'h0);
        chk("rst_s_dout", 64'(sb.rd_dout), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            bload(tbl[i].f0, tbl[i].g0, tbl[i].g23);
            brun(tbl[i].mode, tbl[i].acc, lat, b1, v1);
            chk($sformatf("lat%0d", i), 64'(lat), 64'(PB + 1));
            chk($sformatf("busy1_%0d", i), 64'(b1), 64'h1);
            chk($sformatf("valid1_%0d", i), 64'(v1), 64'h0);
            bcheck($sformatf("vec%0d", i), tbl[i].exp0);
        end

        // start beats a same-cycle write; writes during RUN are dropped
        bload(64'h4, 64'h0, G760);
        @(negedge clk);
        bb.start = 1'b1;
        bb.mode = 2'd0;
        bb.acc_en = 1'b0;
        bb.wr_en = 1'b1;
        bb.wr_sel = 1'b0;
        bb.wr_addr = '0;
        bb.wr_din = 64'h5555_5555_5555_5555;
        @(posedge clk);
        #1;
        bb.start = 1'b0;
        bb.wr_en = 1'b0;
        repeat (100) @(posedge clk);
        bwr(1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        bwr(1'b0, 0, 64'h5555_5555_5555_5555);
        bwr(1'b1, 23, 64'h5555_5555_5555_5555);
        bwait(lat);
        chk("wr_run_valid", 64'(bb.valid), 64'h1);
        bcheck("wr_ign", 64'h5);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bb.start = 1'b1;
        bb.mode = 2'd0;
        bb.acc_en = 1'b0;
        @(posedge clk);
        #1 bb.start = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        chk("mid_busy", 64'(bb.busy), 64'h1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(bb.busy), 64'h0);
        chk("arst_valid", 64'(bb.valid), 64'h0);
        chk("arst_dout", bb.rd_dout, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        bcheck("arst_h", 64'h0);
        brun(2'd0, 1'b0, lat, b1, v1);
        chk("arst_lat", 64'(lat), 64'(PB + 1));
        bcheck("arst_fg", 64'h0);

        for (int tr = 0; tr < 200; tr++) begin
            for (int k = 0; k < PS; k++) begin
                fcd[k] = 2'($urandom_range(0, 3));
                gcd[k] = 2'($urandom_range(0, 3));
                fm[k] = (fcd[k] == 2'd3) ? 0 : int'(fcd[k]);
                gm[k] = (gcd[k] == 2'd3) ? 0 : int'(gcd[k]);
            end
            swr(1'b0, 0, {fcd[3], fcd[2], fcd[1], fcd[0]});
            swr(1'b0, 1, {6'($urandom), fcd[4]});
            swr(1'b1, 0, {gcd[3], gcd[2], gcd[1], gcd[0]});
            swr(1'b1, 1, {6'($urandom), gcd[4]});
            swr(1'($urandom_range(0, 1)), $urandom_range(2, 7),
                8'($urandom));
            m = 2'($urandom_range(0, 3));
            acc = 1'($urandom_range(0, 1));
            model(int'(m), acc);
            e0 = {2'(hm[3]), 2'(hm[2]), 2'(hm[1]), 2'(hm[0])};
            e1 = {6'h0, 2'(hm[4])};
            srun(m, acc, lat);
            chk($sformatf("s_lat%0d", tr), 64'(lat), 64'(PS + 1));
            sread(0, d8);
            chk($sformatf("s_w0_%0d", tr), 64'(d8), 64'(e0));
            sread(1, d8);
            chk($sformatf("s_w1_%0d", tr), 64'(d8), 64'(e1));
            sread($urandom_range(2, 7), d8);
            chk($sformatf("s_hi_%0d", tr), 64'(d8), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
